ring_counter_mm: RTL and testbench
==================================

Name: ring_counter_mm

Overview:
- Parametrised multi-mode ring counter, successor to the fixed one-hot pipelined ring counter.
- Runtime-selectable modes: one-hot ring or Johnson (twisted ring).
- Also provides direction control, count enable, parallel load, illegal-state self-correction and wrap/error flags.
- Output passes through a STAGES-deep register pipeline with a valid bit; used as a sequencer / phase generator feeding downstream timing logic.

Parameters:
- N, 4, counter width in bits; N >= 2.
- STAGES, 2, output pipeline depth in registers; STAGES >= 1; this is the core-to-q latency.
- SEED, 1, ring-mode reset/recovery value; must be one-hot.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous active-low reset.
- en  input  1  advance the counter one step this cycle.
- dir  input  1  0 = shift toward MSB, 1 = shift toward LSB.
- mode  input  1  0 = ring, 1 = Johnson.
- load  input  1  load load_val into the core this cycle.
- load_val  input  N  parallel load value.
- q  output  N  pipelined counter value.
- q_valid  output  1  q holds a post-reset value.
- wrap  output  1  pulse aligned with q: this value is the mode seed, reached by a step.
- err  output  1  pulse aligned with q: this value came from illegal-state correction.

Behaviour:
- Core register `cs` (N bits), plus flag registers `cw` and `ce`. Pipeline of STAGES entries, each holding {valid, data[N], wrap, err}. All signals are registered; no combinational path from inputs to outputs.
- Reset (reset == 0 at a clk edge):
  - cs = SEED if mode == 0, else 0.
  - cw = 0, ce = 0.
  - Every pipeline entry cleared to zero, so q = 0, q_valid = 0, wrap = 0, err = 0.
  - Reset overrides load and en. Reset mid-run behaves identically.
- Core priority when not in reset: load > en > hold.
  - load = 1: cs = load_val verbatim, even if illegal; cw = 0, ce = 0.
  - en = 1, load = 0, cs legal for the current mode: cs advances one step. cw = 1 iff the new cs equals the mode seed; ce = 0.
  - en = 1, load = 0, cs illegal: cs = mode seed (SEED for ring, 0 for Johnson); ce = 1, cw = 0.
  - en = 0, load = 0: cs holds; cw = 0, ce = 0.
- Step functions:
  - Ring, dir = 0: {cs[N-2:0], cs[N-1]}.
  - Ring, dir = 1: {cs[0], cs[N-1:1]}.
  - Johnson, dir = 0: {cs[N-2:0], ~cs[N-1]}.
  - Johnson, dir = 1: {~cs[0], cs[N-1:1]}.
- Legality:
  - Ring: popcount(cs) == 1.
  - Johnson: at most one i in 0..N-2 with cs[i] != cs[i+1]. This gives 2N legal states.
  - Legality is evaluated against the mode in effect this cycle. A mode or dir change mid-run is allowed; the next step uses the new mode and corrects if the state is illegal for it.
- Periods: ring = N steps; Johnson = 2N steps, in either direction.
- Pipeline, every edge out of reset, unconditional (no stall):
  - pipe[0] <= {1, cs, cw, ce}.
  - pipe[j] <= pipe[j-1].
  - {q_valid, q, wrap, err} = pipe[STAGES-1].
- Latency: q shows a given cs value STAGES edges after cs took it. After reset release, q_valid rises on edge STAGES and stays high until the next reset.
- wrap and err are single-cycle per event and travel with their data; they never assert while q_valid = 0.

Test Plan:
1. N=4, STAGES=2, mode=0, dir=0, en=1 from reset release:
   - cs: 0001, 0010, 0100, 1000, 0001.
   - q_valid = 1 with q = 0001 on edge 2.
   - wrap = 1 exactly when q returns to 0001 after 4 steps.
2. mode=1, dir=0, en=1:
   - q sequence 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000.
   - wrap only on the final 0000.
   - dir=1 from 0000 gives 1000, 1100, ...
3. Ring, dir=1 from 0001:
   - q sequence 1000, 0100, 0010, 0001 with wrap on 0001.
   - en=0 for 3 cycles: q frozen, wrap = 0.
4. Illegal load and correction:
   - load=1, load_val=0110, mode=0, then en=1: cs goes 0110 then 0001.
   - q shows 0110 (err = 0), then 0001 with err = 1, wrap = 0.
   - Same in mode=1 with 0101: recovers to 0000 with err = 1.
5. Priority and reset:
   - load=1 with en=1 and load_val=0100: cs = 0100, no step.
   - reset=0 mid-run with en=1 and load=1: next edge cs = SEED, q = 0, q_valid = 0.
   - After release, q_valid returns after exactly 2 edges.
6. Parameter sweep N=8, STAGES=1, mode=1: period 16 steps, latency 1 edge; mode switch from ring state 00000001 is Johnson-legal, continues to 00000011 with no err.

Source files
------------

// File: rtl/ring_counter_mm.sv
// rtl/ring_counter_mm.sv - multi-mode (ring / Johnson) ring counter with load,
// illegal-state recovery and a STAGES-deep registered output pipeline.
module ring_counter_mm #(
  parameter int          N      = 4,
  parameter int          STAGES = 2,
  parameter logic [N-1:0] SEED  = N'(1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         dir,
  input  logic         mode,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] q,
  output logic         q_valid,
  output logic         wrap,
  output logic         err
);

  localparam int W = N + 3;

  logic [N-1:0] cs, cs_next;
  logic         cw, cw_next;
  logic         ce, ce_next;
  logic [N-1:0] mode_seed;
  logic [N-1:0] step_val;
  logic [N-2:0] edges;
  logic         ring_ok;
  logic         john_ok;
  logic         legal;

  logic [W-1:0] pipe [STAGES];

  // A Johnson state has at most one boundary between adjacent differing bits.
  assign edges     = cs[N-2:0] ^ cs[N-1:1];
  assign ring_ok   = ($countones(cs) == 1);
  assign john_ok   = ($countones(edges) <= 1);
  assign legal     = mode ? john_ok : ring_ok;
  assign mode_seed = mode ? '0 : SEED;

  always_comb begin
    step_val = cs;
    case ({mode, dir})
      2'b00:   step_val = {cs[N-2:0], cs[N-1]};
      2'b01:   step_val = {cs[0], cs[N-1:1]};
      2'b10:   step_val = {cs[N-2:0], ~cs[N-1]};
      default: step_val = {~cs[0], cs[N-1:1]};
    endcase
  end

  always_comb begin
    cs_next = cs;
    cw_next = 1'b0;
    ce_next = 1'b0;
    if (load) begin
      cs_next = load_val;
    end else if (en) begin
      if (legal) begin
        cs_next = step_val;
        cw_next = (step_val == mode_seed);
      end else begin
        cs_next = mode_seed;
        ce_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cs <= mode_seed;
      cw <= 1'b0;
      ce <= 1'b0;
    end else begin
      cs <= cs_next;
      cw <= cw_next;
      ce <= ce_next;
    end
  end

  // Flags ride with their data so wrap/err line up with q at the output.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int j = 0; j < STAGES; j++) pipe[j] <= '0;
    end else begin
      pipe[0] <= {1'b1, cs, cw, ce};
      for (int j = 1; j < STAGES; j++) pipe[j] <= pipe[j-1];
    end
  end

  assign {q_valid, q, wrap, err} = pipe[STAGES-1];

endmodule

// File: tb/tb_ring_counter_mm.sv
// tb/tb_ring_counter_mm.sv - randomized and directed bench for ring_counter_mm
// against a state-index reference model (N=4/STAGES=2 and N=8/STAGES=1).
module tb_ring_counter_mm;

  logic       clk = 1'b0;
  logic       reset, en, dir, mode, load;
  logic [7:0] lv;
  logic [3:0] qa;
  logic       va, wa, ea;
  logic [7:0] qb;
  logic       vb, wb, eb;

  always #5 clk = ~clk;

  ring_counter_mm #(.N(4), .STAGES(2), .SEED(4'b0001)) ua (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(lv[3:0]), .q(qa), .q_valid(va), .wrap(wa), .err(ea)
  );

  ring_counter_mm #(.N(8), .STAGES(1), .SEED(8'b00000001)) ub (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(lv), .q(qb), .q_valid(vb), .wrap(wb), .err(eb)
  );

  int total = 0;
  int bad   = 0;

  int nn [2] = '{4, 8};
  int ss [2] = '{2, 1};
  int m_cs [2];
  int m_cw [2];
  int m_ce [2];
  int mp [2][2];

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Johnson state k: k ones filling from the LSB, then zeros filling from the LSB.
  function automatic int jpat(input int n, input int k);
    int mask = (1 << n) - 1;
    if (k <= n) return (1 << k) - 1;
    return mask ^ ((1 << (k - n)) - 1);
  endfunction

  function automatic int jidx(input int n, input int v);
    for (int k = 0; k < 2 * n; k++) if (jpat(n, k) == v) return k;
    return -1;
  endfunction

  function automatic int ridx(input int n, input int v);
    for (int p = 0; p < n; p++) if (v == (1 << p)) return p;
    return -1;
  endfunction

  task automatic model_edge(input int d);
    int n, mask, p, k;
    n    = nn[d];
    mask = (1 << n) - 1;
    if (!reset) begin
      for (int j = 0; j < 2; j++) mp[d][j] = 0;
      m_cs[d] = mode ? 0 : 1;
      m_cw[d] = 0;
      m_ce[d] = 0;
      return;
    end
    for (int j = ss[d] - 1; j >= 1; j--) mp[d][j] = mp[d][j-1];
    mp[d][0] = (1 << 20) | (m_cs[d] << 2) | (m_cw[d] << 1) | m_ce[d];
    m_cw[d] = 0;
    m_ce[d] = 0;
    if (load) begin
      m_cs[d] = int'(lv) & mask;
    end else if (en) begin
      if (!mode) begin
        p = ridx(n, m_cs[d]);
        if (p < 0) begin
          m_cs[d] = 1;
          m_ce[d] = 1;
        end else begin
          p = dir ? (p + n - 1) % n : (p + 1) % n;
          m_cs[d] = 1 << p;
          m_cw[d] = (m_cs[d] == 1);
        end
      end else begin
        k = jidx(n, m_cs[d]);
        if (k < 0) begin
          m_cs[d] = 0;
          m_ce[d] = 1;
        end else begin
          k = dir ? (k + 2 * n - 1) % (2 * n) : (k + 1) % (2 * n);
          m_cs[d] = jpat(n, k);
          m_cw[d] = (m_cs[d] == 0);
        end
      end
    end
  endtask

  task automatic check_outputs();
    int e;
    e = mp[0][1];
    chk("a_q",     int'(qa), (e >> 2) & 15);
    chk("a_valid", int'(va), (e >> 20) & 1);
    chk("a_wrap",  int'(wa), (e >> 1) & 1);
    chk("a_err",   int'(ea), e & 1);
    e = mp[1][0];
    chk("b_q",     int'(qb), (e >> 2) & 255);
    chk("b_valid", int'(vb), (e >> 20) & 1);
    chk("b_wrap",  int'(wb), (e >> 1) & 1);
    chk("b_err",   int'(eb), e & 1);
  endtask

  task automatic cyc(input logic r, input logic e, input logic d, input logic m,
                     input logic l, input logic [7:0] v);
    reset = r; en = e; dir = d; mode = m; load = l; lv = v;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check_outputs();
  endtask

  int jseq [9] = '{0, 1, 3, 7, 15, 14, 12, 8, 0};

  initial begin
    reset = 1'b0; en = 1'b0; dir = 1'b0; mode = 1'b0; load = 1'b0; lv = '0;
    for (int i = 0; i < 2; i++) begin
      m_cs[i] = 1; m_cw[i] = 0; m_ce[i] = 0; mp[i][0] = 0; mp[i][1] = 0;
    end

    // Ring forward from reset release.
    cyc(0, 1, 0, 0, 1, 8'h0f);
    cyc(0, 1, 0, 0, 0, 8'h00);
    chk("reset_q", int'(qa), 0);
    chk("reset_valid", int'(va), 0);
    cyc(1, 1, 0, 0, 0, 8'h00);
    chk("p1_valid_edge1", int'(va), 0);
    cyc(1, 1, 0, 0, 0, 8'h00);
    chk("p1_q_edge2", int'(qa), 1);
    chk("p1_valid_edge2", int'(va), 1);
    for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 0, 8'h00);
    chk("p1_wrap_q", int'(qa), 1);
    chk("p1_wrap", int'(wa), 1);

    // Johnson forward from zero.
    cyc(0, 0, 0, 1, 0, 8'h00);
    cyc(1, 1, 0, 1, 0, 8'h00);
    cyc(1, 1, 0, 1, 0, 8'h00);
    for (int i = 0; i < 9; i++) begin
      chk("p2_john_q", int'(qa), jseq[i]);
      chk("p2_john_wrap", int'(wa), (i == 8) ? 1 : 0);
      cyc(1, 1, 0, 1, 0, 8'h00);
    end

    // Ring backward, then hold.
    cyc(1, 0, 1, 0, 1, 8'h01);
    for (int i = 0; i < 6; i++) cyc(1, 1, 1, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) cyc(1, 0, 1, 0, 0, 8'h00);
    chk("p3_hold_wrap", int'(wa), 0);

    // Illegal loads and correction in both modes.
    cyc(1, 0, 0, 0, 1, 8'h06);
    cyc(1, 1, 0, 0, 0, 8'h00);
    cyc(1, 0, 0, 0, 0, 8'h00);
    chk("p4_ring_bad_q", int'(qa), 6);
    chk("p4_ring_bad_err", int'(ea), 0);
    cyc(1, 0, 0, 0, 0, 8'h00);
    chk("p4_ring_fix_q", int'(qa), 1);
    chk("p4_ring_fix_err", int'(ea), 1);
    cyc(1, 0, 0, 1, 1, 8'h05);
    cyc(1, 1, 0, 1, 0, 8'h00);
    cyc(1, 0, 0, 1, 0, 8'h00);
    cyc(1, 0, 0, 1, 0, 8'h00);
    chk("p4_john_fix_q", int'(qa), 0);
    chk("p4_john_fix_err", int'(ea), 1);

    // Load beats enable; reset beats both.
    cyc(1, 1, 0, 0, 1, 8'h04);
    cyc(1, 0, 0, 0, 0, 8'h00);
    cyc(1, 0, 0, 0, 0, 8'h00);
    chk("p5_load_pri", int'(qa), 4);
    cyc(0, 1, 0, 0, 1, 8'h08);
    chk("p5_rst_q", int'(qa), 0);
    chk("p5_rst_valid", int'(va), 0);
    cyc(1, 0, 0, 0, 0, 8'h00);
    chk("p5_rel_edge1", int'(va), 0);
    cyc(1, 0, 0, 0, 0, 8'h00);
    chk("p5_rel_edge2", int'(va), 1);
    chk("p5_rel_q", int'(qa), 1);

    // Wide instance: ring seed is Johnson-legal after a mode switch.
    cyc(0, 0, 0, 0, 0, 8'h00);
    cyc(1, 1, 0, 1, 0, 8'h00);
    cyc(1, 0, 0, 1, 0, 8'h00);
    chk("p6_switch_q", int'(qb), 3);
    chk("p6_switch_err", int'(eb), 0);
    cyc(0, 0, 0, 1, 0, 8'h00);
    for (int i = 0; i < 16; i++) cyc(1, 1, 0, 1, 0, 8'h00);
    cyc(1, 0, 0, 1, 0, 8'h00);
    chk("p6_period_q", int'(qb), 0);
    chk("p6_period_wrap", int'(wb), 1);

    // Random mix.
    for (int i = 0; i < 800; i++) begin
      cyc(($urandom_range(0, 49) != 0),
          ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 9) == 0) ? ~dir : dir,
          ($urandom_range(0, 19) == 0) ? ~mode : mode,
          ($urandom_range(0, 9) == 0),
          8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
